// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter between the CPU datapath and the host loader/debug port.
// CPU has priority; the host gets a forced slot after STARVE_LIMIT blocked cycles, or exclusive ownership via host_lock.
module ram_arbiter #(
   parameter int AW           = 8,
   parameter int DW           = 8,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_stall,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   input  logic          host_lock,
   output logic          host_owns,
   output logic          host_gnt,
   output logic          host_rvalid,
   output logic [DW-1:0] host_rdata,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_data_in,
   output logic          ram_rden,
   output logic          ram_wren,
   input  logic [DW-1:0] ram_data_out
);

   localparam logic [1:0] SHARED    = 2'd0;
   localparam logic [1:0] LOCK_WAIT = 2'd1;
   localparam logic [1:0] LOCKED    = 2'd2;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_CPU  = 2'd1;
   localparam logic [1:0] OWN_HOST = 2'd2;

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT - 1);

   logic [1:0] state_q, state_d;
   logic [3:0] starve_cnt_q, starve_cnt_d;
   logic [1:0] rd_owner_q, rd_owner_d;

   // No access is issued while reset is held, so an aborted cycle never touches the RAM.
   always_comb begin
      cpu_gnt  = 1'b0;
      host_gnt = 1'b0;
      if (rst) begin
         case (state_q)
            SHARED: begin
               if (cpu_req && host_req) begin
                  if (starve_cnt_q == STARVE_MAX) host_gnt = 1'b1;
                  else                            cpu_gnt  = 1'b1;
               end else begin
                  cpu_gnt  = cpu_req;
                  host_gnt = host_req;
               end
            end
            default: host_gnt = host_req;
         endcase
      end
   end

   always_comb begin
      ram_addr    = '0;
      ram_data_in = '0;
      ram_rden    = 1'b0;
      ram_wren    = 1'b0;
      if (cpu_gnt) begin
         ram_addr    = cpu_addr;
         ram_data_in = cpu_wdata;
         ram_rden    = ~cpu_we;
         ram_wren    = cpu_we;
      end else if (host_gnt) begin
         ram_addr    = host_addr;
         ram_data_in = host_wdata;
         ram_rden    = ~host_we;
         ram_wren    = host_we;
      end
   end

   always_comb begin
      starve_cnt_d = '0;
      if (host_req && !host_gnt) begin
         starve_cnt_d = (starve_cnt_q == 4'hF) ? starve_cnt_q : starve_cnt_q + 4'd1;
      end

      rd_owner_d = OWN_NONE;
      if (cpu_gnt && !cpu_we)        rd_owner_d = OWN_CPU;
      else if (host_gnt && !host_we) rd_owner_d = OWN_HOST;
   end

   // The lock is only taken once any CPU read already issued has delivered its data.
   always_comb begin
      state_d = state_q;
      case (state_q)
         SHARED: begin
            if (host_lock) state_d = LOCK_WAIT;
         end
         LOCK_WAIT: begin
            if (!host_lock)                 state_d = SHARED;
            else if (rd_owner_q != OWN_CPU) state_d = LOCKED;
         end
         LOCKED: begin
            if (!host_lock) state_d = SHARED;
         end
         default: state_d = SHARED;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= SHARED;
         starve_cnt_q <= '0;
         rd_owner_q   <= OWN_NONE;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         rd_owner_q   <= rd_owner_d;
      end
   end

   assign cpu_stall   = cpu_req & ~cpu_gnt;
   assign host_owns   = (state_q == LOCKED);
   assign cpu_rvalid  = (rd_owner_q == OWN_CPU);
   assign host_rvalid = (rd_owner_q == OWN_HOST);
   assign cpu_rdata   = cpu_rvalid  ? ram_data_out : '0;
   assign host_rdata  = host_rvalid ? ram_data_out : '0;

endmodule
